alu_dispatch_ctrl: RTL and testbench
====================================

ALU_DISPATCH_CTRL -- requirements
Module: alu_dispatch_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width shared with all ALU units.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  op request valid.
REQ-005 in_ready  output  1  controller can accept an op.
REQ-006 in_a, in_b  input  WIDTH each  request operands.
REQ-007 in_fun  input  4  request function code; [3:2] selects unit, [1:0] selects unit op.
REQ-008 a, b  output  WIDTH each  operands driven to all units.
REQ-009 alu_fun  output  4  function code driven to all units.
REQ-010 ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN  output  1 each  one-hot unit enables.
REQ-011 ARITH_out, LOGIC_out, CMP_out, SHIFT_out  input  WIDTH each  registered unit results.
REQ-012 ARITH_flag, LOGIC_flag, CMP_flag, SHIFT_flag  input  1 each  registered unit valid flags.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_data  output  WIDTH  captured result.
REQ-016 out_unit  output  2  unit that produced out_data (= captured in_fun[3:2]).
REQ-017 out_err  output  1  selected unit flag was 0 at capture.

Function
REQ-018 Unit decode of fun[3:2]: 00 ARITH, 01 LOGIC, 10 CMP, 11 SHIFT.
REQ-019 FSM states IDLE, ISSUE, CAPTURE, HOLD; encoding free.
REQ-020 in_ready = 1 only in IDLE; combinational from state.
REQ-021 IDLE: in_valid=1 at edge -> latch in_a, in_b, in_fun into op registers, go ISSUE; else stay.
REQ-022 ISSUE (exactly one cycle): exactly the decoded enable = 1, others 0; go CAPTURE.
REQ-023 a, b, alu_fun = op registers in every state; change only on IDLE accept.
REQ-024 All enables = 0 in IDLE, CAPTURE, HOLD.
REQ-025 CAPTURE (one cycle): at edge, out_data <= selected unit _out, out_err <= ~selected unit _flag, out_unit <= op fun[3:2]; go HOLD.
REQ-026 HOLD: out_valid = 1; out_data, out_unit, out_err stable while out_valid=1 and out_ready=0.
REQ-027 HOLD with out_ready=1 at edge -> go IDLE; out_valid = 0 next cycle.
REQ-028 out_valid = 1 only in HOLD.
REQ-029 Latency: request accepted at edge N -> ISSUE cycle N..N+1, capture at edge N+2, out_valid high from edge N+2.
REQ-030 Max throughput: one op per 4 cycles with out_ready held 1.
REQ-031 in_valid while not IDLE ignored; requester holds request (valid/ready handshake, data not latched).
REQ-032 out_ready in states other than HOLD ignored.
REQ-033 Unit _out/_flag inputs sampled only at CAPTURE edge; other values ignored.
REQ-034 in_fun[1:0]=00 forwarded unchanged; unit response (flag) decides out_err.

Reset
REQ-035 rst_n low -> immediately, regardless of clk: state IDLE, all enables 0, out_valid 0, out_data 0, out_unit 0, out_err 0, a, b, alu_fun 0.
REQ-036 Reset in ISSUE/CAPTURE/HOLD aborts op; pending result discarded; no out_valid pulse after release.
REQ-037 After rst_n rises, in_ready = 1 and first accept possible at the next edge.

Verification
REQ-038 Reset mid-HOLD (out_data=0x0003): drop rst_n between edges -> out_valid, out_data, enables 0 before next edge; in_ready 1.
REQ-039 CMP equal: in_a=0x0005, in_b=0x0005, in_fun=1001, out_ready=1, CMP model 1-cycle registered -> CMP_EN high one cycle only; out_valid at edge N+2; out_data=0x0001, out_unit=10, out_err=0.
REQ-040 CMP less: in_a=0x0002, in_b=0x0007, in_fun=1011 -> out_data=0x0003, out_unit=10; then in_fun=1010 same operands -> out_data=0x0000.
REQ-041 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_data stable 5 cycles; in_ready 0; new in_valid (in_a=0xFFFF) not latched; a stays previous value.
REQ-042 Error: in_fun=0001, ARITH model returns ARITH_flag=0, ARITH_out=0x1234 -> out_data=0x1234, out_unit=00, out_err=1.
REQ-043 Back-to-back: in_valid held 1 with 3 ops, out_ready=1 -> each accepted 4 cycles apart; one enable pulse per op matching fun[3:2]; results in order.

Source files
------------

// File: rtl/alu_dispatch_ctrl.sv
// Dispatch controller: accepts one op, pulses the matching ALU unit enable,
// captures that unit's registered result and holds it until the consumer takes it.
module alu_dispatch_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_fun,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [3:0]       alu_fun,
    output logic             ARITH_EN,
    output logic             LOGIC_EN,
    output logic             CMP_EN,
    output logic             SHIFT_EN,
    input  logic [WIDTH-1:0] ARITH_out,
    input  logic [WIDTH-1:0] LOGIC_out,
    input  logic [WIDTH-1:0] CMP_out,
    input  logic [WIDTH-1:0] SHIFT_out,
    input  logic             ARITH_flag,
    input  logic             LOGIC_flag,
    input  logic             CMP_flag,
    input  logic             SHIFT_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_unit,
    output logic             out_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sel_out;
    logic             sel_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        ARITH_EN   = 1'b0;
        LOGIC_EN   = 1'b0;
        CMP_EN     = 1'b0;
        SHIFT_EN   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ISSUE;
            end
            ISSUE: begin
                case (alu_fun[3:2])
                    2'b00:   ARITH_EN = 1'b1;
                    2'b01:   LOGIC_EN = 1'b1;
                    2'b10:   CMP_EN   = 1'b1;
                    default: SHIFT_EN = 1'b1;
                endcase
                state_next = CAPTURE;
            end
            CAPTURE: state_next = HOLD;
            default: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
        endcase
    end

    // Operand registers feed every unit; they only move on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            b       <= '0;
            alu_fun <= '0;
        end else if (state == IDLE && in_valid) begin
            a       <= in_a;
            b       <= in_b;
            alu_fun <= in_fun;
        end
    end

    always_comb begin
        sel_out  = ARITH_out;
        sel_flag = ARITH_flag;
        case (alu_fun[3:2])
            2'b01: begin
                sel_out  = LOGIC_out;
                sel_flag = LOGIC_flag;
            end
            2'b10: begin
                sel_out  = CMP_out;
                sel_flag = CMP_flag;
            end
            2'b11: begin
                sel_out  = SHIFT_out;
                sel_flag = SHIFT_flag;
            end
            default: ;
        endcase
    end

    // Units register their result on the ISSUE edge, so it is sampled on the CAPTURE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_unit <= '0;
            out_err  <= 1'b0;
        end else if (state == CAPTURE) begin
            out_data <= sel_out;
            out_unit <= alu_fun[3:2];
            out_err  <= ~sel_flag;
        end
    end

endmodule

// File: tb/tb_alu_dispatch_ctrl.sv
// Bench for alu_dispatch_ctrl: unit models, a cycle-level scoreboard model and
// directed scenarios with hand-computed results.
module tb_alu_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [3:0]  in_fun = '0;
    logic [15:0] a, b;
    logic [3:0]  alu_fun;
    logic        ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;
    logic [15:0] ARITH_out, LOGIC_out, CMP_out, SHIFT_out;
    logic        ARITH_flag, LOGIC_flag, CMP_flag, SHIFT_flag;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_unit;
    logic        out_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic cmp_on    = 1'b0;
    logic force_err = 1'b0;
    logic collect   = 1'b0;
    int   cyc       = 0;
    logic [15:0] got_q[$];

    alu_dispatch_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_fun(in_fun),
        .a(a), .b(b), .alu_fun(alu_fun),
        .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
        .ARITH_out(ARITH_out), .LOGIC_out(LOGIC_out), .CMP_out(CMP_out), .SHIFT_out(SHIFT_out),
        .ARITH_flag(ARITH_flag), .LOGIC_flag(LOGIC_flag), .CMP_flag(CMP_flag), .SHIFT_flag(SHIFT_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_unit(out_unit), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] unit_result(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
        case (f)
            4'b0000: return x + y;
            4'b0001: return x - y;
            4'b0010: return x + 16'd1;
            4'b0011: return x - 16'd1;
            4'b0100: return x & y;
            4'b0101: return x | y;
            4'b0110: return x ^ y;
            4'b0111: return ~x;
            4'b1000: return 16'h0000;
            4'b1001: return (x == y) ? 16'h0001 : 16'h0000;
            4'b1010: return (x > y) ? 16'h0002 : 16'h0000;
            4'b1011: return (x < y) ? 16'h0003 : 16'h0000;
            4'b1100: return x << y[3:0];
            4'b1101: return x >> y[3:0];
            4'b1110: return x << 1;
            default: return x >> 1;
        endcase
    endfunction

    // Unit models: one-cycle registered results; garbage whenever not enabled.
    always @(posedge clk) begin
        if (ARITH_EN) begin
            ARITH_out  <= force_err ? 16'h1234 : unit_result(alu_fun, a, b);
            ARITH_flag <= !force_err;
        end else begin
            ARITH_out  <= 16'($urandom);
            ARITH_flag <= 1'($urandom);
        end
        LOGIC_out  <= LOGIC_EN ? unit_result(alu_fun, a, b) : 16'($urandom);
        LOGIC_flag <= LOGIC_EN ? 1'b1 : 1'($urandom);
        CMP_out    <= CMP_EN ? unit_result(alu_fun, a, b) : 16'($urandom);
        CMP_flag   <= CMP_EN ? 1'b1 : 1'($urandom);
        SHIFT_out  <= SHIFT_EN ? unit_result(alu_fun, a, b) : 16'($urandom);
        SHIFT_flag <= SHIFT_EN ? 1'b1 : 1'($urandom);
    end

    // Scoreboard model: tracks one op by cycles elapsed since its acceptance.
    logic        m_busy;
    int          m_age;
    logic [15:0] m_a, m_b, m_data, m_res;
    logic [3:0]  m_fun;
    logic [1:0]  m_unit;
    logic        m_err, m_res_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_age <= 0;
            m_a <= '0; m_b <= '0; m_fun <= '0;
            m_data <= '0; m_unit <= '0; m_err <= 1'b0;
            m_res <= '0; m_res_err <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1; m_age <= 1;
                m_a <= in_a; m_b <= in_b; m_fun <= in_fun;
                m_res_err <= force_err && (in_fun[3:2] == 2'b00);
                m_res <= (force_err && in_fun[3:2] == 2'b00) ? 16'h1234 : unit_result(in_fun, in_a, in_b);
            end
        end else if (m_age < 3) begin
            m_age <= m_age + 1;
            if (m_age == 2) begin
                m_data <= m_res; m_err <= m_res_err; m_unit <= m_fun[3:2];
            end
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("m_in_ready", in_ready, !m_busy);
            check("m_out_valid", out_valid, m_busy && m_age == 3);
            check("m_enables", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN},
                  (m_busy && m_age == 1) ? (4'b1000 >> m_fun[3:2]) : 4'b0000);
            check("m_a", a, m_a);
            check("m_b", b, m_b);
            check("m_alu_fun", alu_fun, m_fun);
            check("m_out_data", out_data, m_data);
            check("m_out_unit", out_unit, m_unit);
            check("m_out_err", out_err, m_err);
        end
        if (collect && out_valid && out_ready) got_q.push_back(out_data);
    end

    // Called at #1 after an edge with the controller idle; consumer always ready.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [3:0] tf,
                          input logic [15:0] ed, input logic [1:0] eu, input logic ee);
        in_valid = 1'b1; in_a = ta; in_b = tb_v; in_fun = tf; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("issue_enable", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 4'b1000 >> tf[3:2]);
        check("issue_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        check("capture_enable", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 4'b0000);
        check("capture_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("hold_out_valid", out_valid, 1'b1);
        check("hold_out_data", out_data, ed);
        check("hold_out_unit", out_unit, eu);
        check("hold_out_err", out_err, ee);
        @(posedge clk); #1;
        check("done_out_valid", out_valid, 1'b0);
        check("done_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc[3];
        logic [15:0] ta[3] = '{16'h00F0, 16'h0001, 16'h1000};
        logic [15:0] tb3[3] = '{16'h0FF0, 16'h0004, 16'h0234};
        logic [3:0]  tf[3] = '{4'b0110, 4'b1100, 4'b0000};
        logic [15:0] te[3] = '{16'h0F00, 16'h0010, 16'h1234};

        // Reset state
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_a", a, 16'h0000);
        check("rst_out_data", out_data, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // CMP equal, then CMP less/greater
        run_op(16'h0005, 16'h0005, 4'b1001, 16'h0001, 2'b10, 1'b0);
        run_op(16'h0002, 16'h0007, 4'b1011, 16'h0003, 2'b10, 1'b0);
        run_op(16'h0002, 16'h0007, 4'b1010, 16'h0000, 2'b10, 1'b0);

        // Error flag from ARITH unit
        force_err = 1'b1;
        run_op(16'h0010, 16'h0001, 4'b0001, 16'h1234, 2'b00, 1'b1);
        force_err = 1'b0;

        // Backpressure in HOLD, with a competing request that must not be latched
        in_valid = 1'b1; in_a = 16'h0002; in_b = 16'h0007; in_fun = 4'b1011; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 16'hFFFF;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, 16'h0003);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_a", a, 16'h0002);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_a = 16'h0000; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_a", a, 16'h0002);

        // Reset asserted between edges while holding a result
        in_valid = 1'b1; in_a = 16'h0002; in_b = 16'h0007; in_fun = 4'b1011; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_hold_data", out_data, 16'h0003);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_data", out_data, 16'h0000);
        check("arst_enables", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 4'b0000);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_a", a, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_valid", out_valid, 1'b0);
        run_op(16'h0003, 16'h0004, 4'b0000, 16'h0007, 2'b00, 1'b0);

        // Back-to-back with in_valid held high
        collect = 1'b1;
        got_q.delete();
        for (int k = 0; k < 3; k++) begin
            int waited;
            in_valid = 1'b1; in_a = ta[k]; in_b = tb3[k]; in_fun = tf[k];
            waited = 0;
            @(negedge clk);
            while (!in_ready && waited < 10) begin
                waited++;
                @(negedge clk);
            end
            if (waited >= 10) check("b2b_accept_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            acc[k] = cyc;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        collect = 1'b0;
        check("b2b_gap01", 32'(acc[1] - acc[0]), 32'd4);
        check("b2b_gap12", 32'(acc[2] - acc[1]), 32'd4);
        check("b2b_count", 32'(got_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_q.size()) check("b2b_result", got_q[k], te[k]);
            else check("b2b_result_missing", 32'd0, 32'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
